// File: rtl/stack_alu_seq.sv
// Stack ALU sequencer driving an external LIFO; optional multiply via STACK_ALU_MUL_EN.
// Latency: command-to-next-accept is 2 cycles for PUSH/POP, 3 for binary ops, 1 for a rejected command.
// Backpressure: cmd_ready only in IDLE; one command in flight, cmd_valid ignored while busy.
module stack_alu_seq #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [15:0]   cmd_imm,
    output logic          lifo_push,
    output logic          lifo_pop,
    output logic [15:0]   lifo_data,
    input  logic [15:0]   lifo_q,
    input  logic [CW-1:0] lifo_count,
    output logic          res_valid,
    output logic [15:0]   res_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPB    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  op_a;
    logic [2:0]   op_r;

    logic         is_push;
    logic         is_pop;
    logic         is_bin;
    logic         op_illegal;
    logic         stack_full;
    logic         stack_lt2;
    logic         reject;
    logic         take;

    logic         push_c;
    logic         pop_c;
    logic [15:0]  data_c;

    logic [16:0]  sum;
    logic [15:0]  alu_res;
    logic         alu_c;

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign take      = cmd_valid && cmd_ready;

    assign is_push    = (cmd_op == OP_PUSH);
    assign is_pop     = (cmd_op == OP_POP);
    assign is_bin     = !is_push && !is_pop;
`ifdef STACK_ALU_MUL_EN
    assign op_illegal = 1'b0;
`else
    assign op_illegal = (cmd_op == OP_MUL);
`endif
    assign stack_full = (lifo_count == CW'(DEPTH));
    assign stack_lt2  = (lifo_count < CW'(2));

    assign reject = (is_push && stack_full)
                  || (is_pop && (lifo_count == '0))
                  || (is_bin && (op_illegal || stack_lt2));

    // ALU: lifo_q holds the deeper operand (b) while in OPB
    assign sum = {1'b0, lifo_q} + {1'b0, op_a};

`ifdef STACK_ALU_MUL_EN
    logic [15:0] mul_lo;
    assign mul_lo = lifo_q * op_a;
`endif

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_r)
            OP_ADD: begin
                alu_res = sum[15:0];
                alu_c   = sum[16];
            end
            OP_SUB: begin
                alu_res = lifo_q - op_a;
                alu_c   = (lifo_q < op_a);
            end
            OP_AND: alu_res = lifo_q & op_a;
            OP_OR:  alu_res = lifo_q | op_a;
            OP_XOR: alu_res = lifo_q ^ op_a;
`ifdef STACK_ALU_MUL_EN
            OP_MUL: alu_res = mul_lo;
`endif
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        data_c    = '0;
        case (state)
            IDLE: begin
                if (cmd_valid && !reject) begin
                    if (is_push) begin
                        push_c    = 1'b1;
                        data_c    = cmd_imm;
                        state_nxt = SETTLE;
                    end else if (is_pop) begin
                        pop_c     = 1'b1;
                        state_nxt = SETTLE;
                    end else begin
                        pop_c     = 1'b1;
                        state_nxt = OPB;
                    end
                end
            end
            OPB: begin
                // simultaneous push+pop replaces the top with the result
                push_c    = 1'b1;
                pop_c     = 1'b1;
                data_c    = alu_res;
                state_nxt = SETTLE;
            end
            SETTLE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are combinational; qualify with reset so none leak while it is held
    assign lifo_push = push_c & reset;
    assign lifo_pop  = pop_c & reset;
    assign lifo_data = reset ? data_c : 16'h0000;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_r      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            res_valid <= 1'b0;
            err       <= 1'b0;
            if (take) begin
                if (reject) begin
                    err <= 1'b1;
                end else begin
                    op_r <= cmd_op;
                    if (is_pop) begin
                        res_data  <= lifo_q;
                        res_valid <= 1'b1;
                        flag_z    <= (lifo_q == 16'h0000);
                    end else if (is_bin) begin
                        op_a <= lifo_q;
                    end
                end
            end
            if (state == OPB) begin
                res_data  <= alu_res;
                res_valid <= 1'b1;
                flag_z    <= (alu_res == 16'h0000);
                flag_c    <= alu_c;
            end
        end
    end

endmodule

// File: doc/stack_alu_seq.md
STACK_ALU_SEQ -- requirements
Module: stack_alu_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning capacity of the downstream LIFO in 16-bit words.
REQ-002 SHALL have parameter CW, default 5, meaning width of lifo_count, equal to ceil(log2(DEPTH+1)).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_op  input  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 MUL.
REQ-008 SHALL have port cmd_imm  input  16  immediate for PUSH.
REQ-009 SHALL have ports lifo_push (output, 1), lifo_pop (output, 1) and lifo_data (output, 16), which drive the LIFO push, pop and data inputs.
REQ-010 SHALL have ports lifo_q (input, 16; registered top of stack, valid the cycle after any push/pop) and lifo_count (input, CW; current depth).
REQ-011 SHALL have ports res_valid (output, 1; one-cycle pulse) and res_data (output, 16; popped or computed value).
REQ-012 SHALL have ports flag_z (output, 1; result zero) and flag_c (output, 1; ADD carry-out / SUB borrow).
REQ-013 SHALL have ports err (output, 1; one-cycle pulse on a rejected command) and busy (output, 1; FSM not in IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, OPB, SETTLE; cmd_ready = (state==IDLE); busy = !cmd_ready.
REQ-015 SHALL assert lifo_push/lifo_pop for exactly one cycle per LIFO operation, never in SETTLE.
REQ-016 PUSH: if lifo_count==DEPTH, err pulse and stay IDLE; else lifo_push=1, lifo_data=cmd_imm, go to SETTLE.
REQ-017 POP: if lifo_count==0, err; else res_data<=lifo_q, res_valid pulse on the next cycle, lifo_pop=1, go to SETTLE.
REQ-018 Binary op (2-7): if lifo_count<2, err and no LIFO activity; else op_a<=lifo_q, lifo_pop=1, go to OPB.
REQ-019 OPB: op_b=lifo_q; result = op_b OP op_a (deeper operand on the left); drive lifo_push=1 and lifo_pop=1 in the same cycle with lifo_data=result (top replaced, depth -1 net); res_data<=result; res_valid pulse; go to SETTLE.
REQ-020 Arithmetic SHALL be 16-bit modulo; ADD: flag_c = bit 16 of the 17-bit sum; SUB: flag_c=1 iff op_b<op_a; MUL: low 16 bits of the product, flag_c=0; logic ops: flag_c=0.
REQ-021 flag_z/flag_c SHALL update only with res_valid (POP: flag_z from the popped value, flag_c unchanged) and hold otherwise.
REQ-022 SETTLE SHALL last exactly one cycle, then go to IDLE; command-to-next-accept latency: PUSH/POP 2 cycles, binary op 3 cycles.
REQ-023 A rejected command SHALL be consumed (accepted with err), leaving LIFO state, res_data and the flags unchanged.
REQ-024 Only one command SHALL be in flight; cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-025 On reset low: state=IDLE, lifo_push=lifo_pop=0, lifo_data=0, res_valid=0, res_data=0, flag_z=0, flag_c=0, err=0, op_a=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abort it with no further LIFO strobes; the first accept is possible on the first clock edge after release.

Configuration
REQ-027 Macro STACK_ALU_MUL_EN: when defined, opcode 7 = MUL per REQ-020; when undefined, opcode 7 is illegal and produces an err pulse with no LIFO activity, and no multiplier is synthesised.

Verification
REQ-028 Reset then PUSH 0x0005 and PUSH 0x0003, then SUB -> res_data=0x0002, flag_c=0, and lifo_count ends at 1.
REQ-029 PUSH 0xFFFF and PUSH 0x0001, then ADD -> res_data=0x0000, flag_z=1, flag_c=1.
REQ-030 POP with lifo_count=0 -> err pulse of one cycle, no lifo_pop, cmd_ready=1 on the next cycle.
REQ-031 Fill to DEPTH=16, then PUSH 0x1234 -> err pulse with lifo_count still 16; POP -> res_data equals the last pushed value.
REQ-032 PUSH 0x0004 and PUSH 0x0003, then op 7 -> res_data=0x000C with STACK_ALU_MUL_EN defined; without it, err pulse and lifo_count stays 2.
REQ-033 Reset asserted during OPB -> busy=0 and lifo_push=lifo_pop=0 immediately, with no res_valid.
